// File: rtl/vid_capture.sv
// Video capture engine: samples RGB444 video, decimates 2:1 in X and Y, packs RGB332 bytes into
// 32-bit framebuffer writes. Define VID_CAPTURE_DITHER_EN to add ordered dither before truncation.
module vid_capture #(
    parameter int unsigned H_OUT      = 320,
    parameter int unsigned V_OUT      = 200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] vin_data,
    input  logic        vin_hsync,
    input  logic        vin_vsync,
    input  logic        vin_de,
    output logic [13:0] fb_addr,
    output logic [31:0] fb_wdata,
    output logic [3:0]  fb_wmsk,
    output logic        fb_we,
    input  logic        fb_rdy,
    input  logic        wb_addr,
    output logic [31:0] wb_rdata,
    input  logic [31:0] wb_wdata,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic        wb_ack
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [9:0] HOut = 10'(H_OUT);
    localparam logic [9:0] VOut = 10'(V_OUT);
    localparam logic [9:0] VOutLast = 10'(V_OUT - 1);
    localparam logic [CntW-1:0] FifoFull = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StWaitVs, StCapture, StDrain} state_e;

    state_e state_q, state_d;
    logic count_frame_q, count_frame_d;
    logic [11:0] vin_data_q;
    logic vsync_q, vsync_qq, de_q, de_qq;
    logic [10:0] x_cnt_q, line_cnt_q, y_q, y_cur;
    logic [1:0] byte_idx_q;
    logic [23:0] word_acc_q;
    logic [31:0] word_q;
    logic word_done_q;
    logic [13:0] wr_addr_q;
    logic enable_q, arm_q, ovf_q;
    logic [15:0] frame_cnt_q;
    logic [45:0] fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q;

    logic vs_fall, de_rise, de_fall, run, in_capture, capture_start, abort;
    logic line_kept, last_line, pix_keep, pop, full, push_ok, drop, drain_empty;
    logic frame_done, wb_req, wb_wr, busy;
    logic [3:0] r_adj, g_adj, b_adj;
    logic [7:0] pix_byte;
    logic [31:0] rd_val;

    assign vs_fall       = vsync_qq & ~vsync_q;
    assign de_rise       = de_q & ~de_qq;
    assign de_fall       = de_qq & ~de_q;
    assign run           = enable_q | arm_q;
    assign in_capture    = (state_q == StCapture);
    assign capture_start = vs_fall & ((state_q == StWaitVs) | in_capture);
    assign abort         = in_capture & ~run;
    // The first pixel of a line arrives together with the DE rising edge.
    assign y_cur         = de_rise ? line_cnt_q : y_q;
    assign line_kept     = ~y_cur[0] && (y_cur[10:1] < VOut);
    assign last_line     = ~y_q[0] && (y_q[10:1] == VOutLast);
    assign pix_keep      = in_capture && run && de_q && line_kept && ~x_cnt_q[0]
                           && (x_cnt_q[10:1] < HOut);

`ifdef VID_CAPTURE_DITHER_EN
    logic dith;
    logic [4:0] r_sum, g_sum, b_sum;
    assign dith  = x_cnt_q[1] ^ y_cur[1];
    assign r_sum = {1'b0, vin_data_q[11:8]} + {4'b0, dith};
    assign g_sum = {1'b0, vin_data_q[7:4]} + {4'b0, dith};
    assign b_sum = {1'b0, vin_data_q[3:0]} + {3'b0, dith, 1'b0};
    assign r_adj = r_sum[4] ? 4'hf : r_sum[3:0];
    assign g_adj = g_sum[4] ? 4'hf : g_sum[3:0];
    assign b_adj = b_sum[4] ? 4'hf : b_sum[3:0];
`else
    assign r_adj = vin_data_q[11:8];
    assign g_adj = vin_data_q[7:4];
    assign b_adj = vin_data_q[3:0];
`endif
    assign pix_byte = {r_adj[3:1], g_adj[3:1], b_adj[3:2]};

    assign pop         = fb_we & fb_rdy;
    assign full        = (count_q == FifoFull);
    assign push_ok     = word_done_q & (~full | pop);
    assign drop        = word_done_q & full & ~pop;
    assign drain_empty = (count_q == '0) & ~word_done_q;
    assign frame_done  = (state_q == StDrain) & drain_empty & count_frame_q;
    assign fb_we       = (count_q != '0);
    assign fb_addr     = fb_we ? fifo_mem[rd_ptr_q][45:32] : 14'h0;
    assign fb_wdata    = fb_we ? fifo_mem[rd_ptr_q][31:0] : 32'h0;
    assign fb_wmsk     = 4'hf;
    assign busy        = (state_q != StIdle);
    assign wb_req      = wb_cyc & ~wb_ack;
    assign wb_wr       = wb_req & wb_we & ~wb_addr;
    assign rd_val      = wb_addr ? {16'h0, frame_cnt_q}
                                 : {22'h0, ovf_q, busy, 6'h0, arm_q, enable_q};

    logic unused_bits;
    assign unused_bits = ^{vin_hsync, wb_wdata[31:10], wb_wdata[8:2], r_adj[0], g_adj[0],
                           b_adj[1:0]};

    always_comb begin
        state_d       = state_q;
        count_frame_d = count_frame_q;
        unique case (state_q)
            StIdle:   if (run) state_d = StWaitVs;
            StWaitVs: begin
                if (!run) state_d = StIdle;
                else if (vs_fall) state_d = StCapture;
            end
            StCapture: begin
                if (!run) begin
                    state_d       = StDrain;
                    count_frame_d = 1'b0;
                end else if (de_fall && last_line && !vs_fall) begin
                    state_d       = StDrain;
                    count_frame_d = 1'b1;
                end
            end
            StDrain: begin
                if (drain_empty) begin
                    state_d = (enable_q | (arm_q & ~count_frame_q)) ? StWaitVs : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            count_frame_q <= 1'b0;
            vin_data_q    <= 12'h0;
            vsync_q       <= 1'b1;
            vsync_qq      <= 1'b1;
            de_q          <= 1'b0;
            de_qq         <= 1'b0;
            x_cnt_q       <= '0;
            line_cnt_q    <= '0;
            y_q           <= '0;
            byte_idx_q    <= '0;
            word_acc_q    <= '0;
            word_q        <= '0;
            word_done_q   <= 1'b0;
            wr_addr_q     <= '0;
        end else begin
            state_q       <= state_d;
            count_frame_q <= count_frame_d;
            vin_data_q    <= vin_data;
            vsync_q       <= vin_vsync;
            vsync_qq      <= vsync_q;
            de_q          <= vin_de;
            de_qq         <= de_q;
            if (!de_q) x_cnt_q <= '0;
            else if (!(&x_cnt_q)) x_cnt_q <= x_cnt_q + 11'd1;
            if (capture_start) begin
                line_cnt_q <= '0;
                y_q        <= '0;
            end else if (de_rise) begin
                y_q <= line_cnt_q;
                if (!(&line_cnt_q)) line_cnt_q <= line_cnt_q + 11'd1;
            end
            word_done_q <= 1'b0;
            if (capture_start || abort) begin
                byte_idx_q <= '0;
            end else if (pix_keep) begin
                byte_idx_q <= byte_idx_q + 2'd1;
                case (byte_idx_q)
                    2'd0: word_acc_q[7:0]   <= pix_byte;
                    2'd1: word_acc_q[15:8]  <= pix_byte;
                    2'd2: word_acc_q[23:16] <= pix_byte;
                    default: begin
                        word_q      <= {pix_byte, word_acc_q};
                        word_done_q <= 1'b1;
                    end
                endcase
            end
            // A word still in flight at restart keeps the address it was assembled for.
            if (capture_start) wr_addr_q <= '0;
            else if (word_done_q) wr_addr_q <= wr_addr_q + 14'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= {wr_addr_q, word_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (push_ok && !pop) count_q <= count_q + CntW'(1);
            else if (!push_ok && pop) count_q <= count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q    <= 1'b0;
            arm_q       <= 1'b0;
            ovf_q       <= 1'b0;
            frame_cnt_q <= 16'h0;
            wb_ack      <= 1'b0;
            wb_rdata    <= 32'h0;
        end else begin
            wb_ack   <= wb_req;
            wb_rdata <= wb_req ? rd_val : 32'h0;
            if (drop) ovf_q <= 1'b1;
            if (frame_done) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
                arm_q       <= 1'b0;
            end
            // Register writes come last so they win over hardware updates.
            if (wb_wr) begin
                enable_q <= wb_wdata[0];
                arm_q    <= wb_wdata[1];
                if (wb_wdata[9]) ovf_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vid_capture.sv
// Directed bench for vid_capture with a reduced 8x4 output window and 20x10 active input frames.
module tb_vid_capture;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] vin_data;
    logic        vin_hsync, vin_vsync, vin_de;
    logic [13:0] fb_addr;
    logic [31:0] fb_wdata;
    logic [3:0]  fb_wmsk;
    logic        fb_we, fb_rdy;
    logic        wb_addr;
    logic [31:0] wb_rdata, wb_wdata;
    logic        wb_we, wb_cyc, wb_ack;

    int n_checks = 0;
    int n_errors = 0;
    int cur_line;
    int exp_frames;
    logic [31:0] rd;
    logic [13:0] addr_log[$];
    logic [31:0] data_log[$];
    logic [13:0] exp_addr[$];
    logic [31:0] exp_data[$];

    vid_capture #(.H_OUT(8), .V_OUT(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .vin_data(vin_data), .vin_hsync(vin_hsync),
        .vin_vsync(vin_vsync), .vin_de(vin_de), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .fb_wmsk(fb_wmsk), .fb_we(fb_we), .fb_rdy(fb_rdy), .wb_addr(wb_addr),
        .wb_rdata(wb_rdata), .wb_wdata(wb_wdata), .wb_we(wb_we), .wb_cyc(wb_cyc),
        .wb_ack(wb_ack)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fb_we && fb_rdy) begin
            addr_log.push_back(fb_addr);
            data_log.push_back(fb_wdata);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic a, input logic [31:0] d);
        tick();
        wb_cyc = 1'b1; wb_we = 1'b1; wb_addr = a; wb_wdata = d;
        tick();
        wb_cyc = 1'b0; wb_we = 1'b0; wb_wdata = 32'h0;
    endtask

    task automatic wb_read(input logic a, output logic [31:0] d);
        tick();
        wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = a;
        tick();
        d = wb_ack ? wb_rdata : 32'hdead_beef;
        wb_cyc = 1'b0;
    endtask

    function automatic logic [11:0] pix(input int mode, input int x);
        logic [3:0] v;
        v = 4'(x);
        case (mode)
            0:       return {v, v, v};
            1:       return 12'h999;
            default: return 12'hfff;
        endcase
    endfunction

    // Hand-derived RGB332 words; k is the kept-line index, odd addresses hold x=8..14.
    function automatic logic [31:0] word_exp(input int mode, input int a);
        int k;
        k = a / 2;
        case (mode)
`ifdef VID_CAPTURE_DITHER_EN
            0: if (k % 2 == 0) return (a % 2 == 1) ? 32'hffdb_b792 : 32'h6e49_2500;
               else return (a % 2 == 1) ? 32'hffdb_b692 : 32'h6d49_2400;
            1: return (k % 2 == 0) ? 32'hb692_b692 : 32'h92b6_92b6;
`else
            0: return (a % 2 == 1) ? 32'hffdb_b692 : 32'h6d49_2400;
            1: return 32'h9292_9292;
`endif
            default: return 32'hffff_ffff;
        endcase
    endfunction

    task automatic expect_words(input int mode, input int first, input int last);
        for (int a = first; a <= last; a++) begin
            exp_addr.push_back(14'(a));
            exp_data.push_back(word_exp(mode, a));
        end
    endtask

    task automatic check_log(input string tag);
        int n;
        check_eq({tag, "_count"}, 32'(addr_log.size()), 32'(exp_addr.size()));
        n = (addr_log.size() < exp_addr.size()) ? addr_log.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), 32'(addr_log[i]), 32'(exp_addr[i]));
            check_eq($sformatf("%s_data%0d", tag, i), data_log[i], exp_data[i]);
        end
        addr_log.delete(); data_log.delete(); exp_addr.delete(); exp_data.delete();
    endtask

    task automatic send_frame(input int n_lines, input int mode);
        vin_vsync = 1'b0;
        repeat (2) tick();
        vin_vsync = 1'b1;
        repeat (4) tick();
        for (int l = 0; l < n_lines; l++) begin
            cur_line = l;
            vin_hsync = 1'b0;
            repeat (2) tick();
            vin_hsync = 1'b1;
            repeat (2) tick();
            for (int x = 0; x < 20; x++) begin
                vin_de = 1'b1;
                vin_data = pix(mode, x);
                tick();
            end
            vin_de = 1'b0;
            vin_data = 12'h0;
            repeat (4) tick();
        end
        cur_line = n_lines;
        repeat (4) tick();
    endtask

    task automatic check_csr(input string tag, input logic [31:0] csr, input logic [15:0] cnt);
        wb_read(1'b0, rd);
        check_eq({tag, "_csr"}, rd, csr);
        wb_read(1'b1, rd);
        check_eq({tag, "_frame_cnt"}, rd, {16'h0, cnt});
    endtask

    initial begin
        rst = 1'b1; vin_data = 12'h0; vin_hsync = 1'b1; vin_vsync = 1'b1; vin_de = 1'b0;
        fb_rdy = 1'b1; wb_addr = 1'b0; wb_wdata = 32'h0; wb_we = 1'b0; wb_cyc = 1'b0;
        cur_line = -1; exp_frames = 0;
        repeat (3) tick();
        rst = 1'b0;
        check_eq("rst_fb_we", {31'h0, fb_we}, 32'h0);
        check_eq("rst_fb_addr", {18'h0, fb_addr}, 32'h0);
        check_eq("rst_fb_wdata", fb_wdata, 32'h0);
        check_eq("rst_wb_ack", {31'h0, wb_ack}, 32'h0);
        check_eq("rst_wb_rdata", wb_rdata, 32'h0);
        check_eq("fb_wmsk", {28'h0, fb_wmsk}, 32'hf);
        check_csr("rst", 32'h0, 16'h0);

        // Armed single frame, gradient pixels.
        wb_write(1'b0, 32'h2);
        wb_read(1'b0, rd);
        check_eq("armed_csr", rd, 32'h102);
        send_frame(10, 0);
        repeat (30) tick();
        exp_frames++;
        expect_words(0, 0, 7);
        check_log("arm_frame");
        check_csr("arm_done", 32'h0, 16'(exp_frames));

        // Stall the framebuffer through line 4: words 4 and 5 are dropped.
        addr_log.delete(); data_log.delete();
        wb_write(1'b0, 32'h2);
        cur_line = -1;
        fork
            send_frame(10, 0);
            begin
                fb_rdy = 1'b0;
                wait (cur_line == 5);
                fb_rdy = 1'b1;
            end
        join
        repeat (30) tick();
        exp_frames++;
        expect_words(0, 0, 3);
        expect_words(0, 6, 7);
        check_log("ovf_frame");
        check_csr("ovf_set", 32'h200, 16'(exp_frames));
        wb_write(1'b0, 32'h200);
        wb_read(1'b0, rd);
        check_eq("ovf_clear", rd, 32'h0);

        // Short frame: VSYNC after five lines restarts at address 0.
        wb_write(1'b0, 32'h2);
        send_frame(5, 0);
        check_csr("short", 32'h102, 16'(exp_frames));
        send_frame(10, 0);
        repeat (30) tick();
        exp_frames++;
        expect_words(0, 0, 5);
        expect_words(0, 0, 7);
        check_log("short_frame");
        check_csr("short_done", 32'h0, 16'(exp_frames));

        // Continuous mode over three frames, then disable mid-frame.
        wb_write(1'b0, 32'h1);
        for (int f = 0; f < 3; f++) begin
            send_frame(10, 0);
            expect_words(0, 0, 7);
        end
        repeat (30) tick();
        exp_frames += 3;
        check_log("enable_frames");
        cur_line = -1;
        fork
            send_frame(10, 0);
            begin
                wait (cur_line == 4);
                wb_write(1'b0, 32'h0);
            end
        join
        repeat (30) tick();
        expect_words(0, 0, 3);
        check_log("disable_mid");
        check_csr("disabled", 32'h0, 16'(exp_frames));
        send_frame(10, 0);
        check_log("disabled_idle");

        // Constant colours.
        wb_write(1'b0, 32'h2);
        send_frame(10, 1);
        repeat (30) tick();
        expect_words(1, 0, 7);
        check_log("const_999");
        wb_write(1'b0, 32'h2);
        send_frame(10, 2);
        repeat (30) tick();
        exp_frames += 2;
        expect_words(2, 0, 7);
        check_log("const_fff");
        check_csr("const_done", 32'h0, 16'(exp_frames));

        // Reset in the middle of a capture with words queued.
        wb_write(1'b0, 32'h2);
        cur_line = -1;
        fork
            send_frame(10, 0);
            begin
                fb_rdy = 1'b0;
                wait (cur_line == 3);
                check_eq("pre_reset_fb_we", {31'h0, fb_we}, 32'h1);
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check_eq("post_reset_fb_we", {31'h0, fb_we}, 32'h0);
                fb_rdy = 1'b1;
            end
        join
        repeat (30) tick();
        check_log("after_reset");
        check_csr("after_reset", 32'h0, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
